// File: rtl/can_error_frame_ctrl.sv
// CAN error/overload frame sequencer: drives flag, waits for recessive bus, then
// delimiter and intermission bit by bit on the sample-point strobe.
module can_error_frame_ctrl #(
  parameter int FLAG_BITS    = 6,
  parameter int DELIM_BITS   = 8,
  parameter int INTER_BITS   = 3,
  parameter int STUCK_BITS   = 8,
  parameter int MAX_OVERLOAD = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       samplePoint,
  input  logic       rxBit,
  input  logic       errorReq,
  input  logic       overloadReq,
  input  logic       errorPassive,
  output logic       txBit,
  output logic       busy,
  output logic       interframe,
  output logic       frameDone,
  output logic       sofDetected,
  output logic       stuckDominant,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ERR_FLAG     = 3'd1;
  localparam logic [2:0] OVL_FLAG     = 3'd2;
  localparam logic [2:0] WAIT_REC     = 3'd3;
  localparam logic [2:0] DELIM        = 3'd4;
  localparam logic [2:0] INTERMISSION = 3'd5;

  localparam int DW = $clog2(STUCK_BITS + 1);
  localparam int OW = $clog2(MAX_OVERLOAD + 1);

  localparam logic [3:0]    FLAG_LAST  = 4'(FLAG_BITS - 1);
  localparam logic [3:0]    DELIM_LAST = 4'(DELIM_BITS - 1);
  localparam logic [3:0]    INTER_LAST = 4'(INTER_BITS);
  localparam logic [DW-1:0] STUCK_LAST = DW'(STUCK_BITS - 1);
  localparam logic [OW-1:0] OVL_MAX    = OW'(MAX_OVERLOAD);

  // bit_cnt: flag bits done in a flag state, delimiter bits seen in DELIM,
  // current intermission bit number (1-based) in INTERMISSION.
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [DW-1:0] dom_cnt, dom_cnt_n;
  logic [OW-1:0] ovl_cnt, ovl_cnt_n;
  logic          err_pend, err_pend_n;
  logic          ovl_pend, ovl_pend_n;
  logic [2:0]    state_n;
  logic          tx_n, done_n, sof_n, stuck_n;
  logic          go_err, go_ovl, err_clr, ovl_clr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    dom_cnt_n = dom_cnt;
    ovl_cnt_n = ovl_cnt;
    tx_n      = txBit;
    done_n    = 1'b0;
    sof_n     = 1'b0;
    stuck_n   = 1'b0;
    go_err    = 1'b0;
    go_ovl    = 1'b0;
    err_clr   = 1'b0;
    ovl_clr   = 1'b0;

    if (samplePoint) begin
      case (state)
        IDLE: begin
          if (err_pend)      go_err = 1'b1;
          else if (ovl_pend) go_ovl = 1'b1;
        end
        ERR_FLAG, OVL_FLAG: begin
          if (bit_cnt == FLAG_LAST) begin
            state_n   = WAIT_REC;
            dom_cnt_n = '0;
            tx_n      = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        WAIT_REC: begin
          // The first recessive sample already counts as delimiter bit 1.
          if (rxBit) begin
            state_n   = DELIM;
            bit_cnt_n = 4'd1;
          end else if (dom_cnt == STUCK_LAST) begin
            stuck_n   = 1'b1;
            dom_cnt_n = '0;
          end else begin
            dom_cnt_n = dom_cnt + DW'(1);
          end
        end
        DELIM: begin
          if (!rxBit) begin
            go_err = 1'b1;
          end else if (bit_cnt == DELIM_LAST) begin
            state_n   = INTERMISSION;
            bit_cnt_n = 4'd1;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        INTERMISSION: begin
          if (err_pend) begin
            go_err = 1'b1;
          end else if (!rxBit) begin
            // Early dominant is an overload unless the overload budget is spent.
            if (bit_cnt < INTER_LAST && ovl_cnt != OVL_MAX) begin
              go_ovl = 1'b1;
            end else begin
              sof_n     = 1'b1;
              state_n   = IDLE;
              ovl_cnt_n = '0;
            end
          end else if (bit_cnt == INTER_LAST) begin
            done_n    = 1'b1;
            state_n   = IDLE;
            ovl_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end

    if (go_err) begin
      state_n   = ERR_FLAG;
      bit_cnt_n = '0;
      tx_n      = errorPassive;
      err_clr   = 1'b1;
      ovl_clr   = 1'b1;
    end else if (go_ovl) begin
      state_n   = OVL_FLAG;
      bit_cnt_n = '0;
      tx_n      = 1'b0;
      ovl_clr   = 1'b1;
      if (ovl_cnt != OVL_MAX) ovl_cnt_n = ovl_cnt + OW'(1);
    end

    // A request in the same cycle as the clear stays latched.
    err_pend_n = (err_pend & ~err_clr) | errorReq;
    ovl_pend_n = (ovl_pend & ~ovl_clr) | overloadReq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      dom_cnt       <= '0;
      ovl_cnt       <= '0;
      err_pend      <= 1'b0;
      ovl_pend      <= 1'b0;
      txBit         <= 1'b1;
      busy          <= 1'b0;
      interframe    <= 1'b1;
      frameDone     <= 1'b0;
      sofDetected   <= 1'b0;
      stuckDominant <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      dom_cnt       <= dom_cnt_n;
      ovl_cnt       <= ovl_cnt_n;
      err_pend      <= err_pend_n;
      ovl_pend      <= ovl_pend_n;
      txBit         <= tx_n;
      busy          <= (state_n != IDLE);
      interframe    <= (state_n == IDLE) || (state_n == INTERMISSION);
      frameDone     <= done_n;
      sofDetected   <= sof_n;
      stuckDominant <= stuck_n;
    end
  end

endmodule

// File: tb/tb_can_error_frame_ctrl.sv
// Self-checking bench for can_error_frame_ctrl: vector table, directed corner
// sequences, and randomized traffic against a bit-timeline reference model.
module tb_can_error_frame_ctrl;

  localparam int FLAG_BITS    = 6;
  localparam int DELIM_BITS   = 8;
  localparam int INTER_BITS   = 3;
  localparam int STUCK_BITS   = 8;
  localparam int MAX_OVERLOAD = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EFLAG = 3'd1;
  localparam logic [2:0] S_OFLAG = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DELIM = 3'd4;
  localparam logic [2:0] S_INTER = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sp = 1'b0, rx = 1'b1, ereq = 1'b0, oreq = 1'b0, epass = 1'b0;
  logic txBit, busy, interframe, frameDone, sofDetected, stuckDominant;
  logic [2:0] state;
  logic [8:0] dut_out;

  can_error_frame_ctrl #(
    .FLAG_BITS(FLAG_BITS), .DELIM_BITS(DELIM_BITS), .INTER_BITS(INTER_BITS),
    .STUCK_BITS(STUCK_BITS), .MAX_OVERLOAD(MAX_OVERLOAD)
  ) dut (
    .clock(clk), .reset(rst_n), .samplePoint(sp), .rxBit(rx),
    .errorReq(ereq), .overloadReq(oreq), .errorPassive(epass),
    .txBit(txBit), .busy(busy), .interframe(interframe), .frameDone(frameDone),
    .sofDetected(sofDetected), .stuckDominant(stuckDominant), .state(state)
  );

  assign dut_out = {txBit, busy, interframe, frameDone, sofDetected, stuckDominant, state};

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {tx,busy,ifs,done,sof,stuck,state}=%b want %b", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pack_exp(input logic tx, input logic [2:0] st,
                                          input logic done, input logic sof, input logic stuck);
    return {tx, st != S_IDLE, (st == S_IDLE) || (st == S_INTER), done, sof, stuck, st};
  endfunction

  // Reference model: tracks which field of the frame is on the bus and how many
  // bits of it have elapsed.
  typedef enum {P_IDLE, P_EFLAG, P_OFLAG, P_WAIT, P_DELIM, P_INTER} phase_e;
  phase_e m_phase;
  int     m_pos, m_dom, m_ovl;
  bit     m_epend, m_opend, m_tx, m_done, m_sof, m_stuck;

  task automatic model_init();
    m_phase = P_IDLE; m_pos = 0; m_dom = 0; m_ovl = 0;
    m_epend = 0; m_opend = 0; m_tx = 1; m_done = 0; m_sof = 0; m_stuck = 0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic er,
                            input logic orq, input logic ep);
    bit go_err = 0, go_ovl = 0, clr_e = 0, clr_o = 0;
    m_done = 0; m_sof = 0; m_stuck = 0;
    if (s) begin
      case (m_phase)
        P_IDLE: begin
          if (m_epend) go_err = 1;
          else if (m_opend) go_ovl = 1;
        end
        P_EFLAG, P_OFLAG: begin
          m_pos++;
          if (m_pos == FLAG_BITS) begin m_phase = P_WAIT; m_dom = 0; m_tx = 1; end
        end
        P_WAIT: begin
          if (r) begin m_phase = P_DELIM; m_pos = 1; end
          else begin
            m_dom++;
            if (m_dom == STUCK_BITS) begin m_stuck = 1; m_dom = 0; end
          end
        end
        P_DELIM: begin
          if (!r) go_err = 1;
          else begin
            m_pos++;
            if (m_pos == DELIM_BITS) begin m_phase = P_INTER; m_pos = 0; end
          end
        end
        P_INTER: begin
          if (m_epend) go_err = 1;
          else if (!r) begin
            if (m_pos + 1 < INTER_BITS && m_ovl < MAX_OVERLOAD) go_ovl = 1;
            else begin m_sof = 1; m_phase = P_IDLE; m_ovl = 0; end
          end else if (m_pos + 1 == INTER_BITS) begin
            m_done = 1; m_phase = P_IDLE; m_ovl = 0;
          end else m_pos++;
        end
        default: m_phase = P_IDLE;
      endcase
    end
    if (go_err) begin
      m_phase = P_EFLAG; m_pos = 0; m_tx = ep; clr_e = 1; clr_o = 1;
    end else if (go_ovl) begin
      m_phase = P_OFLAG; m_pos = 0; m_tx = 0; clr_o = 1;
      if (m_ovl < MAX_OVERLOAD) m_ovl++;
    end
    m_epend = (m_epend && !clr_e) || er;
    m_opend = (m_opend && !clr_o) || orq;
  endtask

  function automatic logic [8:0] model_out();
    logic [2:0] st;
    case (m_phase)
      P_EFLAG: st = S_EFLAG;
      P_OFLAG: st = S_OFLAG;
      P_WAIT:  st = S_WAIT;
      P_DELIM: st = S_DELIM;
      P_INTER: st = S_INTER;
      default: st = S_IDLE;
    endcase
    return pack_exp(m_tx, st, m_done, m_sof, m_stuck);
  endfunction

  // One clock: inputs change 1ns after the previous edge, outputs are read 1ns after this one.
  task automatic cyc(input logic s, input logic r, input logic er, input logic orq);
    sp = s; rx = r; ereq = er; oreq = orq;
    @(posedge clk);
    model_step(s, r, er, orq, epass);
    #1;
  endtask

  task automatic do_reset();
    sp = 0; rx = 1; ereq = 0; oreq = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_init();
  endtask

  task automatic samples(input int n, input logic r);
    for (int k = 0; k < n; k++) cyc(1'b1, r, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       sp, rx, er, orq, ep;
    logic       tx_e;
    logic [2:0] st_e;
    logic       done_e;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic s, input logic r, input logic er, input logic orq,
                         input logic ep, input logic tx_e, input logic [2:0] st_e,
                         input logic done_e);
    vec_t v;
    v.sp = s; v.rx = r; v.er = er; v.orq = orq; v.ep = ep;
    v.tx_e = tx_e; v.st_e = st_e; v.done_e = done_e;
    tbl.push_back(v);
  endtask

  // Clean error frame, bus mirrors txBit; flag bit 1 is sample 1, frameDone at sample 17.
  task automatic add_frame(input logic p);
    add_vec(0, 1, 1, 0, p, 1, S_IDLE, 0);
    add_vec(1, 1, 0, 0, p, p, S_EFLAG, 0);
    add_vec(0, 1, 0, 0, p, p, S_EFLAG, 0);
    for (int k = 1; k <= 6; k++)
      add_vec(1, p, 0, 0, p, (k < 6) ? p : 1'b1, (k < 6) ? S_EFLAG : S_WAIT, 0);
    add_vec(1, 1, 0, 0, p, 1, S_DELIM, 0);
    for (int k = 8; k <= 14; k++)
      add_vec(1, 1, 0, 0, p, 1, (k < 14) ? S_DELIM : S_INTER, 0);
    add_vec(1, 1, 0, 0, p, 1, S_INTER, 0);
    add_vec(1, 1, 0, 0, p, 1, S_INTER, 0);
    add_vec(1, 1, 0, 0, p, 1, S_IDLE, 1);
    add_vec(0, 1, 0, 0, p, 1, S_IDLE, 0);
  endtask

  initial begin
    add_frame(1'b0);
    add_frame(1'b1);

    // Reset values
    @(posedge clk); #1;
    check("reset_vals", dut_out, pack_exp(1, S_IDLE, 0, 0, 0));
    rst_n = 1'b1;
    model_init();

    for (int i = 0; i < tbl.size(); i++) begin
      epass = tbl[i].ep;
      cyc(tbl[i].sp, tbl[i].rx, tbl[i].er, tbl[i].orq);
      check($sformatf("tbl%0d", i), dut_out,
            pack_exp(tbl[i].tx_e, tbl[i].st_e, tbl[i].done_e, 0, 0));
    end
    epass = 1'b0;

    // Reset in the middle of an error flag, with a pending request that must be lost
    do_reset();
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    samples(2, 1'b0);
    cyc(0, 0, 1, 0);
    sp = 0; ereq = 0;
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_out, pack_exp(1, S_IDLE, 0, 0, 0));
    @(posedge clk); #1;
    check("rst_edge", dut_out, pack_exp(1, S_IDLE, 0, 0, 0));
    rst_n = 1'b1;
    model_init();
    cyc(1, 1, 0, 0);
    check("rst_pend_lost", dut_out, pack_exp(1, S_IDLE, 0, 0, 0));

    // Stuck dominant after own flag
    do_reset();
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    samples(6, 1'b0);
    check("stuck_wait", dut_out, pack_exp(1, S_WAIT, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("stuck_dom%0d", i), dut_out, pack_exp(1, S_WAIT, 0, 0, i == STUCK_BITS));
    end
    cyc(1, 1, 0, 0);
    check("stuck_delim", dut_out, pack_exp(1, S_DELIM, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1, 0, 0);
      check($sformatf("stuck_tail%0d", i), dut_out,
            pack_exp(1, (i < 7) ? S_DELIM : ((i < 10) ? S_INTER : S_IDLE), i == 10, 0, 0));
    end

    // Three dominant first intermission bits: two overload frames, then SOF
    do_reset();
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    samples(6, 1'b0);
    samples(8, 1'b1);
    check("ovl_pre", dut_out, pack_exp(1, S_INTER, 0, 0, 0));
    for (int ov = 1; ov <= MAX_OVERLOAD; ov++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("ovl%0d_enter", ov), dut_out, pack_exp(0, S_OFLAG, 0, 0, 0));
      for (int k = 1; k <= 6; k++) begin
        cyc(1, 0, 0, 0);
        check($sformatf("ovl%0d_flag%0d", ov, k), dut_out,
              pack_exp((k < 6) ? 1'b0 : 1'b1, (k < 6) ? S_OFLAG : S_WAIT, 0, 0, 0));
      end
      samples(8, 1'b1);
      check($sformatf("ovl%0d_inter", ov), dut_out, pack_exp(1, S_INTER, 0, 0, 0));
    end
    cyc(1, 0, 0, 0);
    check("ovl_sof", dut_out, pack_exp(1, S_IDLE, 0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      check($sformatf("ovl_after%0d", k), dut_out, pack_exp(1, S_IDLE, 0, 0, 0));
    end

    // Form error at delimiter bit 3
    do_reset();
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    samples(6, 1'b0);
    samples(2, 1'b1);
    check("form_delim", dut_out, pack_exp(1, S_DELIM, 0, 0, 0));
    cyc(1, 0, 0, 0);
    check("form_err", dut_out, pack_exp(0, S_EFLAG, 0, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("form_flag%0d", k), dut_out,
            pack_exp((k < 6) ? 1'b0 : 1'b1, (k < 6) ? S_EFLAG : S_WAIT, 0, 0, 0));
    end

    // Error and overload requested together: one error frame, no overload afterwards
    do_reset();
    cyc(0, 1, 1, 1);
    cyc(1, 1, 0, 0);
    check("both_eflag", dut_out, pack_exp(0, S_EFLAG, 0, 0, 0));
    samples(6, 1'b0);
    samples(8, 1'b1);
    samples(3, 1'b1);
    check("both_done", dut_out, pack_exp(1, S_IDLE, 1, 0, 0));
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 0);
      check($sformatf("both_idle%0d", k), dut_out, pack_exp(1, S_IDLE, 0, 0, 0));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic s, r, er, orq;
      s   = ($urandom_range(2) == 0);
      r   = m_tx;
      if ($urandom_range(9) == 0) r = 1'b0;
      er  = ($urandom_range(79) == 0);
      orq = ($urandom_range(59) == 0);
      if ($urandom_range(199) == 0) epass = ~epass;
      cyc(s, r, er, orq);
      check($sformatf("rand%0d", i), dut_out, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
